// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed 4-digit BCD display scanner with tear-free commit and leading-zero blanking
// Ports: CLK/RST_N clock and async active-low reset; Value/Load new 4-digit BCD value and its load strobe;
// Enable anode enable; LampTest lamp-test request; LzBlank leading-zero blanking enable;
// BCD/LightTest/BLanking/LatchEnable decoder controls; DigitSel one-hot anodes;
// Busy value awaiting commit; Ack one-cycle commit pulse.
module disp_scan_ctrl #(
  parameter int DEAD = 2,
  parameter int DWELL = 1000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic        Enable,
  input  logic        LampTest,
  input  logic        LzBlank,
  output logic [3:0]  BCD,
  output logic        LightTest,
  output logic        BLanking,
  output logic        LatchEnable,
  output logic [3:0]  DigitSel,
  output logic        Busy,
  output logic        Ack
);
  localparam int CW = $clog2((DEAD > DWELL ? DEAD : DWELL) + 1);
  typedef enum logic {st_dead, st_show} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] shadow, shadow_n, pending;
  logic pend, pend_n, run, last, commit, lz;
  logic [3:0] bcd_n, sel_n;
  logic lt_n, bl_n, le_n;
  // run holds the sequencer for the first edge after reset so that edge starts DEAD of digit 0
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      run <= 1'b0;
      state <= st_dead;
      idx <= '0;
      cnt <= '0;
      shadow <= '0;
      pending <= '0;
      pend <= 1'b0;
      BCD <= '0;
      LightTest <= 1'b1;
      BLanking <= 1'b0;
      LatchEnable <= 1'b0;
      DigitSel <= '0;
      Ack <= 1'b0;
    end else begin
      run <= 1'b1;
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      shadow <= shadow_n;
      if (Load) pending <= Value;
      pend <= pend_n;
      BCD <= bcd_n;
      LightTest <= lt_n;
      BLanking <= bl_n;
      LatchEnable <= le_n;
      DigitSel <= sel_n;
      Ack <= commit;
    end
  always_comb begin
    last = state == st_dead ? cnt == CW'(DEAD - 1) : cnt == CW'(DWELL - 1);
    commit = run && state == st_show && idx == 2'd3 && last && pend;
    state_n = !run ? st_dead : last ? (state == st_dead ? st_show : st_dead) : state;
    idx_n = run && state == st_show && last ? idx + 2'd1 : idx;
    cnt_n = !run || last ? '0 : cnt + CW'(1);
    shadow_n = commit ? pending : shadow;
    pend_n = Load | (pend & ~commit);
  end
  // outputs are registered copies of what the next state will present
  always_comb begin
    bcd_n = shadow_n[{idx_n, 2'b00} +: 4];
    lz = LzBlank && idx_n != 2'd0 && (shadow_n >> {idx_n, 2'b00}) == 16'd0;
    bl_n = LampTest | ~lz;
    lt_n = ~LampTest;
    le_n = state_n == st_show;
    sel_n = state_n == st_show && Enable ? 4'b0001 << idx_n : 4'b0000;
  end
  assign Busy = pend;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: self-checking bench for disp_scan_ctrl with DEAD=2, DWELL=4 (24-cycle frame)
module tb_disp_scan_ctrl;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [15:0] Value = '0;
  logic Load = 1'b0, Enable = 1'b1, LampTest = 1'b0, LzBlank = 1'b0;
  logic [3:0] BCD, DigitSel;
  logic LightTest, BLanking, LatchEnable, Busy, Ack;
  disp_scan_ctrl #(.DEAD(2), .DWELL(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .Value(Value), .Load(Load), .Enable(Enable),
    .LampTest(LampTest), .LzBlank(LzBlank), .BCD(BCD), .LightTest(LightTest),
    .BLanking(BLanking), .LatchEnable(LatchEnable), .DigitSel(DigitSel), .Busy(Busy), .Ack(Ack)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [3:0] bcd, sel;
    logic light, bl, le, busy, ack;
  } exp_t;
  typedef struct {
    logic [15:0] value;
    logic lzb, lt;
    logic [3:0] bl;
    logic light;
  } vec_t;
  exp_t q[$];
  vec_t vecs[7];
  int checks = 0, errors = 0;
  int m_t, lp;
  logic [15:0] m_sh, m_pv;
  logic m_pend;
  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (model t=%0d)", n, got, exp, m_t);
    end
  endtask
  task automatic model_reset();
    m_t = 0; m_sh = '0; m_pv = '0; m_pend = 1'b0; lp = 0;
    q.delete();
  endtask
  task automatic chk_reset();
    chk("rst_bcd", 16'(BCD), 16'h0);
    chk("rst_lighttest", 16'(LightTest), 16'h1);
    chk("rst_blanking", 16'(BLanking), 16'h0);
    chk("rst_latch", 16'(LatchEnable), 16'h0);
    chk("rst_digitsel", 16'(DigitSel), 16'h0);
    chk("rst_busy", 16'(Busy), 16'h0);
    chk("rst_ack", 16'(Ack), 16'h0);
  endtask
  // called at a falling edge: drive, predict, clock, compare
  task automatic step(input logic ld, input logic [15:0] v);
    exp_t e;
    int pos, d;
    logic commit, show;
    Load = ld;
    Value = v;
    pos = m_t % 24;
    commit = m_t > 0 && pos == 0 && m_pend;
    if (commit) m_sh = m_pv;
    if (ld) begin
      m_pv = v;
      m_pend = 1'b1;
    end else if (commit) m_pend = 1'b0;
    d = pos / 6;
    show = (pos % 6) >= 2;
    e.bcd = m_sh[d*4 +: 4];
    e.sel = show && Enable ? 4'(1 << d) : 4'd0;
    e.le = show;
    e.light = !LampTest;
    e.bl = LampTest || !(LzBlank && d > 0 && (m_sh >> (4 * d)) == 16'd0);
    e.busy = m_pend;
    e.ack = commit;
    q.push_back(e);
    lp = pos;
    m_t++;
    @(posedge CLK);
    #1;
    e = q.pop_front();
    chk("bcd", 16'(BCD), 16'(e.bcd));
    chk("digitsel", 16'(DigitSel), 16'(e.sel));
    chk("latch", 16'(LatchEnable), 16'(e.le));
    chk("lighttest", 16'(LightTest), 16'(e.light));
    chk("blanking", 16'(BLanking), 16'(e.bl));
    chk("busy", 16'(Busy), 16'(e.busy));
    chk("ack", 16'(Ack), 16'(e.ack));
    Load = 1'b0;
    @(negedge CLK);
  endtask
  task automatic run_to(input int p);
    for (int k = 0; k < 30 && lp != p; k++) step(1'b0, 16'h0);
    chk("run_to_pos", 16'(lp), 16'(p));
  endtask
  task automatic wait_ack();
    for (int k = 0; k < 30 && !Ack; k++) step(1'b0, 16'h0);
    chk("ack_seen", 16'(Ack), 16'h1);
  endtask
  initial begin
    int acks, rises;
    logic [3:0] blg;
    logic lg, le_prev;
    vecs[0] = '{16'h0070, 1'b1, 1'b0, 4'b0011, 1'b1};
    vecs[1] = '{16'h0000, 1'b1, 1'b0, 4'b0001, 1'b1};
    vecs[2] = '{16'h0000, 1'b1, 1'b1, 4'b1111, 1'b0};
    vecs[3] = '{16'h1234, 1'b1, 1'b0, 4'b1111, 1'b1};
    vecs[4] = '{16'h0000, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[5] = '{16'h00AF, 1'b1, 1'b0, 4'b0011, 1'b1};
    vecs[6] = '{16'h0500, 1'b1, 1'b0, 4'b0111, 1'b1};
    @(negedge CLK);
    chk_reset();
    RST_N = 1'b1;
    model_reset();
    // frame timing: two frames of DigitSel against the hand pattern
    for (int i = 0; i < 48; i++) begin
      step(1'b0, 16'h0);
      chk("frame_sel", 16'(DigitSel), ((i % 24) % 6) >= 2 ? 16'(1 << ((i % 24) / 6)) : 16'h0);
    end
    // tear-free commit loaded mid digit 1
    run_to(8);
    step(1'b1, 16'h1234);
    chk("tear_busy", 16'(Busy), 16'h1);
    wait_ack();
    chk("tear_bcd0", 16'(BCD), 16'h4);
    step(1'b0, 16'h0);
    chk("tear_ack_once", 16'(Ack), 16'h0);
    // back-to-back loads: latest wins, single Ack
    step(1'b1, 16'h1111);
    step(1'b1, 16'h2222);
    acks = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b0, 16'h0);
      if (Ack) begin
        acks++;
        chk("b2b_bcd0", 16'(BCD), 16'h2);
      end
    end
    chk("b2b_acks", 16'(acks), 16'h1);
    // load on the commit cycle
    step(1'b1, 16'h3333);
    run_to(23);
    step(1'b1, 16'h5678);
    chk("cc_ack", 16'(Ack), 16'h1);
    chk("cc_busy", 16'(Busy), 16'h1);
    chk("cc_bcd0", 16'(BCD), 16'h3);
    acks = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 16'h0);
      if (Ack) acks++;
    end
    chk("cc_second_ack", 16'(acks), 16'h1);
    chk("cc_bcd0_new", 16'(BCD), 16'h8);
    chk("cc_busy_clear", 16'(Busy), 16'h0);
    // enable off: anodes dark, latch keeps toggling
    Enable = 1'b0;
    rises = 0;
    le_prev = LatchEnable;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 16'h0);
      chk("en_off_sel", 16'(DigitSel), 16'h0);
      if (LatchEnable && !le_prev) rises++;
      le_prev = LatchEnable;
    end
    chk("en_off_le_rises", 16'(rises), 16'h4);
    Enable = 1'b1;
    // blanking and lamp-test table
    for (int v = 0; v < 7; v++) begin
      LzBlank = vecs[v].lzb;
      LampTest = vecs[v].lt;
      step(1'b1, vecs[v].value);
      wait_ack();
      blg = '0;
      lg = 1'b1;
      for (int i = 0; i < 24; i++) begin
        step(1'b0, 16'h0);
        if ((lp % 6) >= 2) blg[lp / 6] = BLanking;
        lg = LightTest;
      end
      chk($sformatf("vec%0d_blanking", v), 16'(blg), 16'(vecs[v].bl));
      chk($sformatf("vec%0d_lighttest", v), 16'(lg), 16'(vecs[v].light));
    end
    LampTest = 1'b0;
    LzBlank = 1'b0;
    // reset during SHOW of digit 2 with a value pending
    step(1'b1, 16'h9876);
    run_to(15);
    #2 RST_N = 1'b0;
    #1 chk_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 16'h0);
      if (Ack) acks++;
    end
    chk("rst_no_ack", 16'(acks), 16'h0);
    chk("rst_busy_after", 16'(Busy), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
- REQ-001 SHALL have parameter DEAD, default 2: dead-time cycles per digit, with all anodes off and the decoder latch transparent; legal range >= 1.
- REQ-002 SHALL have parameter DWELL, default 1000: display cycles per digit, with anode on and decoder latch holding; legal range >= 1.
- REQ-003 SHALL have port CLK, input, width 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port RST_N, input, width 1: reset, asynchronous and active-low.
- REQ-005 SHALL have port Value, input, width 16: four BCD digits; [15:12] is digit 3 (MSD), [3:0] is digit 0 (LSD).
- REQ-006 SHALL have port Load, input, width 1: request to display Value; sampled every cycle.
- REQ-007 SHALL have port Enable, input, width 1: 0 forces all anodes off.
- REQ-008 SHALL have port LampTest, input, width 1: 1 requests all segments lit.
- REQ-009 SHALL have port LzBlank, input, width 1: 1 enables leading-zero blanking.
- REQ-010 SHALL have port BCD, output, width 4: decoder data input.
- REQ-011 SHALL have port LightTest, output, width 1: decoder lamp-test input, active-low.
- REQ-012 SHALL have port BLanking, output, width 1: decoder blanking input, active-low.
- REQ-013 SHALL have port LatchEnable, output, width 1: decoder latch control; 0 is transparent, 1 is hold.
- REQ-014 SHALL have port DigitSel, output, width 4: one-hot anode select, active-high; bit i drives digit i.
- REQ-015 SHALL have port Busy, output, width 1: 1 while a loaded value awaits commit.
- REQ-016 SHALL have port Ack, output, width 1: one-cycle pulse when a pending value is committed.
- REQ-017 SHALL register all outputs (no combinational input-to-output paths).

Function
- REQ-018 SHALL keep a 2-bit digit index idx, a cycle counter, a 16-bit shadow register (the displayed value), a 16-bit pending register and a pending flag.
- REQ-019 SHALL implement two states:
  - DEAD: lasts DEAD cycles; DigitSel=0, LatchEnable=0, BCD=shadow digit idx.
  - SHOW: lasts DWELL cycles; LatchEnable=1, DigitSel=one-hot(idx) when Enable=1, else DigitSel=0.
- REQ-020 SHALL transition DEAD to SHOW after DEAD cycles, and SHOW to DEAD after DWELL cycles with idx incremented modulo 4 (3 wraps to 0).
- REQ-021 SHALL make the frame period exactly 4*(DEAD+DWELL) cycles, with digit order 0,1,2,3.
- REQ-022 SHALL hold BCD constant throughout DEAD and the following SHOW of the same digit.
- REQ-023 SHALL, on any cycle with Load=1, write pending<=Value and set the pending flag to 1; a later Load before commit overwrites the pending value (latest wins).
- REQ-024 SHALL commit only at frame end (the last SHOW cycle of idx=3) when the pending flag is 1; on commit, shadow<=pending, the pending flag clears, and Ack=1 for the next cycle only.
- REQ-025 SHALL, when Load=1 coincides with the commit cycle, commit the old pending value and store the new Value as pending, leaving the pending flag at 1.
- REQ-026 SHALL drive Busy equal to the pending flag.
- REQ-027 SHALL blank digit i (i=1..3) when LzBlank=1 and shadow digits 3 down to i are all 0; digit 0 is never leading-zero blanked.
- REQ-028 SHALL drive BLanking=0 for a blanked digit and BLanking=1 otherwise.
- REQ-029 SHALL, when LampTest=1, drive LightTest=0 and BLanking=1 regardless of blanking; otherwise LightTest=1.
- REQ-030 SHALL apply LampTest, LzBlank and Enable changes within one cycle; the sequencer timing is unaffected by them.
- REQ-031 SHALL pass shadow digit values greater than 9 unmodified to BCD; the decoder blanks them.

Reset
- REQ-032 SHALL, while RST_N=0, force asynchronously:
  - state=DEAD, idx=0, counter=0;
  - shadow=0, pending=0, pending flag=0;
  - outputs BCD=0, LightTest=1, BLanking=0, LatchEnable=0, DigitSel=0, Busy=0, Ack=0.
- REQ-033 SHALL, on RST_N deassertion, start the first DEAD period of digit 0 on the next rising edge; reset mid-frame discards the pending value with no Ack.

Verification
- REQ-034 SHALL cover frame timing (DEAD=2, DWELL=4): after reset, DigitSel sequence is 0,0 then 0001 x4, 0,0, then 0010 x4, and so on; the pattern repeats every 24 cycles.
- REQ-035 SHALL cover tear-free commit: Value=16'h1234 with Load pulsed mid-digit-1 gives Busy=1 and unchanged BCD until frame end, then Ack one cycle and digit 0 shows BCD=4.
- REQ-036 SHALL cover leading-zero blanking: shadow=16'h0070 with LzBlank=1 gives BLanking=0 on digits 3 and 2 and BLanking=1 on digits 1 and 0; shadow=0 blanks digits 3..1 only.
- REQ-037 SHALL cover lamp test: LampTest=1 with LzBlank=1 and shadow=0 gives LightTest=0 and BLanking=1 on all digits.
- REQ-038 SHALL cover back-to-back Load: Load 16'h1111 then 16'h2222 before frame end gives a single Ack and shadow=16'h2222; Load on the commit cycle leaves Busy=1 and a second Ack one frame later.
- REQ-039 SHALL cover reset and Enable: RST_N low during SHOW of digit 2 gives all outputs at reset values immediately with no Ack; Enable=0 gives DigitSel=0 while LatchEnable keeps toggling.
